// File: rtl/packer_stream_dbuf.sv
// Packs RATIO input words into one wide output word, with a double-buffered assembly/output path.
// Optional stall-cycle counter output (stall_cnt) is enabled by defining PACKER_PERF_EN.
module packer_stream_dbuf #(
    parameter int IN_WIDTH  = 64,
    parameter int RATIO     = 2,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = $clog2(RATIO) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [CNT_W-1:0]          out_cnt,
`ifdef PACKER_PERF_EN
    output logic [31:0]               stall_cnt,
`endif
    output logic                      out_last
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                 state;
    logic [OUT_WIDTH-1:0]   asm_data;
    logic [CNT_W-1:0]       asm_cnt;
    logic                   asm_last;

    logic                   accept;
    logic                   complete;
    logic                   out_free;
    logic [CNT_W-1:0]       slot;
    logic [OUT_WIDTH-1:0]   placed;
    logic [OUT_WIDTH-1:0]   merged;

    assign accept   = in_valid && in_ready;
    assign complete = accept && ((asm_cnt == CNT_W'(RATIO - 1)) || in_last);
    assign out_free = !out_valid || out_ready;
    assign merged   = asm_data | placed;

    always_comb begin
        slot = asm_cnt;
        if (MSB_FIRST != 0) begin
            slot = CNT_W'(RATIO - 1) - asm_cnt;
        end
    end

    always_comb begin
        placed = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (slot == CNT_W'(i)) begin
                placed[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    // In PEND asm_cnt holds the finished word count rather than the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            asm_data  <= '0;
            asm_cnt   <= '0;
            asm_last  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
        end else if (clr) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            asm_data  <= '0;
            asm_cnt   <= '0;
            asm_last  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (complete) begin
                        if (out_free) begin
                            out_data  <= merged;
                            out_cnt   <= asm_cnt + 1'b1;
                            out_last  <= in_last;
                            out_valid <= 1'b1;
                            asm_data  <= '0;
                            asm_cnt   <= '0;
                            asm_last  <= 1'b0;
                        end else begin
                            asm_data  <= merged;
                            asm_cnt   <= asm_cnt + 1'b1;
                            asm_last  <= in_last;
                            in_ready  <= 1'b0;
                            state     <= PEND;
                        end
                    end else if (accept) begin
                        asm_data <= merged;
                        asm_cnt  <= asm_cnt + 1'b1;
                    end
                end
                PEND: begin
                    if (out_ready) begin
                        out_data  <= asm_data;
                        out_cnt   <= asm_cnt;
                        out_last  <= asm_last;
                        out_valid <= 1'b1;
                        asm_data  <= '0;
                        asm_cnt   <= '0;
                        asm_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= FILL;
                    end
                end
                default: begin
                    state    <= FILL;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef PACKER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_packer_stream_dbuf.sv
// Scoreboard bench for packer_stream_dbuf: an LSB-first and an MSB-first instance share stimulus.
module tb_packer_stream_dbuf;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int CW = $clog2(R) + 1;

    typedef struct packed {
        logic [W*R-1:0] d;
        logic [CW-1:0]  cnt;
        logic           last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clr;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           out_ready;

    logic           in_ready_l, out_valid_l, out_last_l;
    logic [W*R-1:0] out_data_l;
    logic [CW-1:0]  out_cnt_l;
    logic           in_ready_m, out_valid_m, out_last_m;
    logic [W*R-1:0] out_data_m;
    logic [CW-1:0]  out_cnt_m;
`ifdef PACKER_PERF_EN
    logic [31:0]    stall_cnt_l, stall_cnt_m;
`endif

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    exp_t q_l[$];
    exp_t q_m[$];
    exp_t e_l, e_m;

    logic [W*R-1:0] m_lsb, m_msb;
    int             m_cnt;

    always #5 clk = ~clk;

    packer_stream_dbuf #(.IN_WIDTH(W), .RATIO(R), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .out_cnt(out_cnt_l),
`ifdef PACKER_PERF_EN
        .stall_cnt(stall_cnt_l),
`endif
        .out_last(out_last_l)
    );

    packer_stream_dbuf #(.IN_WIDTH(W), .RATIO(R), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .out_cnt(out_cnt_m),
`ifdef PACKER_PERF_EN
        .stall_cnt(stall_cnt_m),
`endif
        .out_last(out_last_m)
    );

    // Handshake happens on the following rising edge; inputs only move just after rising edges.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid_l && out_ready) begin
            checks++;
            n_out++;
            if (q_l.size() == 0) begin
                errors++;
                $display("FAIL lsb_unexpected_out got=%h/%0d/%b", out_data_l, out_cnt_l, out_last_l);
            end else begin
                e_l = q_l.pop_front();
                if ({out_data_l, out_cnt_l, out_last_l} !== {e_l.d, e_l.cnt, e_l.last}) begin
                    errors++;
                    $display("FAIL lsb_word got=%h/%0d/%b exp=%h/%0d/%b",
                             out_data_l, out_cnt_l, out_last_l, e_l.d, e_l.cnt, e_l.last);
                end
            end
        end
        if (rst_n && !clr && out_valid_m && out_ready) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL msb_unexpected_out got=%h/%0d/%b", out_data_m, out_cnt_m, out_last_m);
            end else begin
                e_m = q_m.pop_front();
                if ({out_data_m, out_cnt_m, out_last_m} !== {e_m.d, e_m.cnt, e_m.last}) begin
                    errors++;
                    $display("FAIL msb_word got=%h/%0d/%b exp=%h/%0d/%b",
                             out_data_m, out_cnt_m, out_last_m, e_m.d, e_m.cnt, e_m.last);
                end
            end
        end
    end

    task automatic model_reset();
        m_lsb = '0;
        m_msb = '0;
        m_cnt = 0;
        q_l.delete();
        q_m.delete();
    endtask

    task automatic model_push(input logic [W-1:0] d, input logic last);
        exp_t e;
        m_lsb[m_cnt*W +: W]       = d;
        m_msb[(R-1-m_cnt)*W +: W] = d;
        m_cnt++;
        if (m_cnt == R || last) begin
            e.cnt  = CW'(m_cnt);
            e.last = last;
            e.d    = m_lsb;
            q_l.push_back(e);
            e.d    = m_msb;
            q_m.push_back(e);
            m_lsb = '0;
            m_msb = '0;
            m_cnt = 0;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [W-1:0] d, input logic last, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready_l && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%h in_ready=%b", d, in_ready_l);
        end else begin
            model_push(d, last);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((q_l.size() != 0 || q_m.size() != 0) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (q_l.size() != 0 || q_m.size() != 0) begin
            errors++;
            $display("FAIL drain_pending lsb=%0d msb=%0d exp=0", q_l.size(), q_m.size());
        end
        cycles(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        cycles(3);
        checks++;
        if ({out_valid_l, out_data_l, out_cnt_l, out_last_l} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%h/%0d/%b exp=0", out_valid_l, out_data_l, out_cnt_l, out_last_l);
        end
        rst_n = 1'b1;
        cycles(1);
        checks++;
        if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got in_ready=%b out_valid=%b exp=1/0", in_ready_l, out_valid_l);
        end
    endtask

    task automatic test_basic();
        int w;
        send(8'h11, 1'b0, w);
        send(8'h22, 1'b0, w);
        send(8'h33, 1'b0, w);
        checks++;
        if (out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got=%b exp=0", out_valid_l);
        end
        send(8'h44, 1'b0, w);
        checks++;
        if (out_valid_l !== 1'b1 || out_data_l !== 32'h44332211 || out_cnt_l !== 3'd4 || out_last_l !== 1'b0) begin
            errors++;
            $display("FAIL basic_lsb got=%b/%h/%0d/%b exp=1/44332211/4/0", out_valid_l, out_data_l, out_cnt_l, out_last_l);
        end
        checks++;
        if (out_data_m !== 32'h11223344) begin
            errors++;
            $display("FAIL basic_msb got=%h exp=11223344", out_data_m);
        end
        cycles(1);
        checks++;
        if (out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_one_cycle got=%b exp=0", out_valid_l);
        end
        drain();
    endtask

    task automatic test_flush();
        int w;
        send(8'hA1, 1'b0, w);
        send(8'hB2, 1'b1, w);
        checks++;
        if (out_data_l !== 32'h0000B2A1 || out_cnt_l !== 3'd2 || out_last_l !== 1'b1) begin
            errors++;
            $display("FAIL flush_partial got=%h/%0d/%b exp=0000b2a1/2/1", out_data_l, out_cnt_l, out_last_l);
        end
        checks++;
        if (out_data_m !== 32'hA1B20000) begin
            errors++;
            $display("FAIL flush_partial_msb got=%h exp=a1b20000", out_data_m);
        end
        // Next packet must restart at slot 0; last on the final slot gives one full word.
        send(8'hC1, 1'b0, w);
        send(8'hC2, 1'b0, w);
        send(8'hC3, 1'b0, w);
        send(8'hC4, 1'b1, w);
        checks++;
        if (out_data_l !== 32'hC4C3C2C1 || out_cnt_l !== 3'd4 || out_last_l !== 1'b1) begin
            errors++;
            $display("FAIL flush_full_last got=%h/%0d/%b exp=c4c3c2c1/4/1", out_data_l, out_cnt_l, out_last_l);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, w);
        checks++;
        if (in_ready_l !== 1'b0) begin
            errors++;
            $display("FAIL bp_pend_ready got=%b exp=0", in_ready_l);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid_l !== 1'b1 || out_data_l !== 32'h04030201 || in_ready_l !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got=%b/%h ready=%b exp=1/04030201/0", out_valid_l, out_data_l, in_ready_l);
            end
            cycles(1);
        end
`ifdef PACKER_PERF_EN
        checks++;
        if (stall_cnt_l !== 32'd9) begin
            errors++;
            $display("FAIL bp_stall_cnt got=%0d exp=9", stall_cnt_l);
        end
`endif
        out_ready = 1'b1;
        cycles(1);
        checks++;
        if (out_valid_l !== 1'b1 || out_data_l !== 32'h08070605 || in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got=%b/%h ready=%b exp=1/08070605/1", out_valid_l, out_data_l, in_ready_l);
        end
`ifdef PACKER_PERF_EN
        checks++;
        if (stall_cnt_l !== 32'd9) begin
            errors++;
            $display("FAIL bp_stall_after got=%0d exp=9", stall_cnt_l);
        end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int waits = 0;
        int base  = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(8'(i * 3 + 1), 1'b0, w);
            waits += w;
        end
        drain();
        checks++;
        if (waits != 0) begin
            errors++;
            $display("FAIL b2b_ready_drop got_waits=%0d exp=0", waits);
        end
        checks++;
        if (n_out - base != 16) begin
            errors++;
            $display("FAIL b2b_word_count got=%0d exp=16", n_out - base);
        end
    endtask

    task automatic test_clear();
        int w;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h90 + i), 1'b0, w);
        clr = 1'b1;
        model_reset();
        cycles(1);
        clr = 1'b0;
        checks++;
        if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL clr_pend got valid=%b ready=%b exp=0/1", out_valid_l, in_ready_l);
        end
        out_ready = 1'b1;
        send(8'hE1, 1'b0, w);
        send(8'hE2, 1'b0, w);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got valid=%b exp=0", out_valid_l);
        end
        cycles(1);
        rst_n = 1'b1;
        cycles(1);
        checks++;
        if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_packet got valid=%b ready=%b exp=0/1", out_valid_l, in_ready_l);
        end
        send(8'h5A, 1'b0, w);
        send(8'h6B, 1'b0, w);
        send(8'h7C, 1'b0, w);
        send(8'h8D, 1'b0, w);
        checks++;
        if (out_valid_l !== 1'b1 || out_data_l !== 32'h8D7C6B5A || out_cnt_l !== 3'd4) begin
            errors++;
            $display("FAIL clean_after_rst got=%b/%h/%0d exp=1/8d7c6b5a/4", out_valid_l, out_data_l, out_cnt_l);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/packer_stream_dbuf.md
Name: packer_stream_dbuf

Overview:
Parametrised successor of the team's simple width packer. It gathers RATIO input words of IN_WIDTH into one output word of IN_WIDTH*RATIO, using a valid/ready handshake on both sides. The assembly stage and output stage are double-buffered, so a stalled consumer does not drop data. Adds packet-end flush (partial words), selectable word order and a word-count sideband. It sits between PE result streams and wide GLB/DRAM write ports.

Parameters:
IN_WIDTH, 64, input word width in bits
RATIO, 2, input words per output word (>=1); OUT_WIDTH = IN_WIDTH*RATIO
MSB_FIRST, 0, 0: first accepted word in bits [IN_WIDTH-1:0]; 1: first word in top slot
CNT_W, clog2(RATIO)+1, width of word-count sideband

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear, highest priority after rst_n
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
in_data  in  IN_WIDTH  input word
in_last  in  1  last word of packet, forces flush
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts packed word
out_data  out  IN_WIDTH*RATIO  packed word
out_cnt  out  CNT_W  number of valid words in out_data (1..RATIO)
out_last  out  1  packed word closes a packet

Behaviour:
- Reset: clk domain. rst_n is asynchronous, active-low. Reset and clr clear the following to 0: out_valid, out_data, out_cnt, out_last, asm_cnt and the assembly register; state=FILL; in_ready=1 from the first cycle after reset.
- Accept: a word is taken when in_valid && in_ready. When in_ready=0, in_data and in_last are ignored.
- Slot placement: with MSB_FIRST=0, an accepted word is written to slot asm_cnt, bits [asm_cnt*IN_WIDTH +: IN_WIDTH]. With MSB_FIRST=1 it goes to slot RATIO-1-asm_cnt. Unwritten slots of a flushed partial word read 0.
- Complete beat: an accepted word with asm_cnt==RATIO-1 or in_last=1.
- State FILL: in_ready=1. On a non-complete accept, asm_cnt increments. On a complete accept:
  - If the output stage is free (out_valid==0, or out_valid&&out_ready this cycle), load out_data/out_cnt/out_last on the same edge, set out_valid=1, and reset asm_cnt and the assembly register to 0. Stay in FILL.
  - Otherwise keep the assembly register and go to PEND.
- State PEND: in_ready=0. When out_valid&&out_ready, load the assembly register into the output stage on that edge, keep out_valid=1, clear assembly, go to FILL.
- Latency: out_valid rises 1 cycle after the completing beat is accepted.
- Throughput: 1 input word per cycle is sustained when out_ready=1.
- Output holding: out_data, out_cnt and out_last are stable while out_valid&&!out_ready. out_valid falls only after a handshake with nothing to load.
- out_cnt: equals asm_cnt+1 at completion. It is RATIO for full words and less for in_last flushes.
- RATIO==1: every accept is complete. Output data equals input data, registered with 1-cycle latency; out_cnt=1.
- clr during PEND or mid-packet discards all buffered data. No out_valid is produced for discarded data.
- Simultaneous events:
  - out handshake and complete accept in FILL in the same cycle: the new word loads; no bubble.
  - in_last on word RATIO-1: a single full word with out_last=1.

Optional Feature:
Macro PACKER_PERF_EN.
- Defined: adds output port stall_cnt (32 bits). It counts cycles with out_valid&&!out_ready, saturates at 0xFFFFFFFF, and is cleared by rst_n and clr.
- Undefined: the port and counter do not exist. Function and timing are otherwise identical.

Test Plan:
- IN_WIDTH=8, RATIO=4, MSB_FIRST=0, out_ready=1; feed 0x11,0x22,0x33,0x44 on consecutive cycles. Required: out_data=0x44332211, out_cnt=4, out_last=0, out_valid high exactly 1 cycle after the 0x44 accept.
- Same configuration with MSB_FIRST=1. Required: out_data=0x11223344.
- Partial flush: feed 0xA1, then 0xB2 with in_last=1. Required: out_data=0x0000B2A1, out_cnt=2, out_last=1, and the next packet starts at slot 0.
- Backpressure: out_ready=0, stream 8 words 0x01..0x08. Required:
  - First word 0x04030201 holds stable.
  - in_ready drops after the 0x08 accept (PEND).
  - Raising out_ready delivers 0x08070605 on the next cycle with no word lost or duplicated.
  - With PACKER_PERF_EN, stall_cnt equals the number of stalled cycles.
- Continuous stream of 64 words with out_ready=1. Required: in_ready never drops; 16 output words in order.
- clr asserted in PEND, then rst_n pulsed mid-packet. Required: out_valid=0 and in_ready=1 the next cycle; the next 4 words produce a clean word with out_cnt=4.
